// File: rtl/game_pkg.sv
// Purpose : shared types and constants for the round-robin turn scheduler.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package game_pkg;

  localparam int NUM_PLAYERS = 4;
  localparam int PLAYER_W    = $clog2(NUM_PLAYERS);

  // Externally visible state encoding; values are part of the interface.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Round-robin successor; the player index is exactly PLAYER_W bits wide,
  // so the natural wrap of the addition is the modulo.
  function automatic logic [PLAYER_W-1:0] next_player(input logic [PLAYER_W-1:0] p);
    return p + PLAYER_W'(1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Purpose : divides clk down to a one-cycle millisecond tick (count 0..CLK_PER_MS-1).
// Latency : tick is combinational from the registered count (high during the wrap cycle).
// Backpressure: enable low holds the count (partial ms preserved); clear beats enable.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   enable    - advance the count this cycle
//   clear     - force the count back to zero (priority over enable)
//   tick      - high in the cycle the enabled count wraps
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt;

  // Tick is deliberately independent of clear: the controller derives clear
  // from tick, so feeding clear back in here would form a combinational loop.
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Purpose : four-player round-robin turn timer sharing one ms tick, with pause and game-over.
// Latency : all outputs registered; every input takes effect on the next rising edge.
// Backpressure: none; pause freezes the running turn, start/done ignored where not meaningful.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start          - one-cycle pulse, begins a game from IDLE or OVER
//   pause          - level, freezes the running turn while high
//   done[3:0]      - per-player end-of-turn pulse (only the active player's bit counts)
//   active_player  - owner of the current turn
//   ms_left        - milliseconds remaining in the current turn
//   turn_count     - turns completed in this game
//   timeout        - one-cycle pulse when a turn expires
//   state          - IDLE=0, RUN=1, PAUSE=2, OVER=3
module round_scheduler
  import game_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int TURN_MS    = 5000,
  parameter int MAX_TURNS  = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic [NUM_PLAYERS-1:0] done,
  output logic [PLAYER_W-1:0]    active_player,
  output logic [15:0]            ms_left,
  output logic [7:0]             turn_count,
  output logic                   timeout,
  output logic [1:0]             state
);

  localparam logic [15:0] TURN_MS_V   = 16'(TURN_MS);
  localparam logic [7:0]  MAX_TURNS_V = 8'(MAX_TURNS);

  state_t               state_q, state_d;
  logic [PLAYER_W-1:0]  player_q, player_d;
  logic [15:0]          ms_q, ms_d;
  logic [7:0]           turns_q, turns_d;
  logic                 timeout_q, timeout_d;

  logic tick;
  logic tick_en;
  logic tick_clr;
  logic done_act;
  logic expire;

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(tick_en),
    .clear (tick_clr),
    .tick  (tick)
  );

  assign done_act = done[player_q];
  assign expire   = tick && (ms_q == 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      player_q  <= '0;
      ms_q      <= '0;
      turns_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      ms_q      <= ms_d;
      turns_q   <= turns_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    ms_d      = ms_q;
    turns_d   = turns_q;
    timeout_d = 1'b0;
    tick_en   = 1'b0;
    tick_clr  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_RUN;
          player_d = '0;
          ms_d     = TURN_MS_V;
          turns_d  = '0;
          tick_clr = 1'b1;
        end
      end

      ST_RUN: begin
        // Pause gates the divider in the same cycle it is seen, so the
        // partial millisecond is frozen exactly where the player left it.
        if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          tick_en = 1'b1;
          if (done_act || expire) begin
            // A player finishing on the expiring tick is credited, not timed out.
            timeout_d = expire && !done_act;
            tick_clr  = 1'b1;
            turns_d   = (turns_q == 8'hFF) ? turns_q : turns_q + 8'd1;
            if (turns_d == MAX_TURNS_V) begin
              state_d = ST_OVER;
              ms_d    = '0;
            end else begin
              player_d = next_player(player_q);
              ms_d     = TURN_MS_V;
            end
          end else if (tick && (ms_q != 16'd0)) begin
            ms_d = ms_q - 16'd1;
          end
        end
      end

      ST_PAUSE: begin
        if (!pause) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign active_player = player_q;
  assign ms_left       = ms_q;
  assign turn_count    = turns_q;
  assign timeout       = timeout_q;
  assign state         = state_q;

endmodule

// File: tb/tb_round_scheduler.sv
module tb_round_scheduler;

  localparam int CPM   = 4;
  localparam int TMS   = 5;
  localparam int MAXT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  done = 4'b0000;
  logic [1:0]  active_player;
  logic [15:0] ms_left;
  logic [7:0]  turn_count;
  logic        timeout;
  logic [1:0]  state;

  int n_total = 0;
  int n_pass  = 0;

  round_scheduler #(
    .CLK_PER_MS(CPM),
    .TURN_MS   (TMS),
    .MAX_TURNS (MAXT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .done         (done),
    .active_player(active_player),
    .ms_left      (ms_left),
    .turn_count   (turn_count),
    .timeout      (timeout),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Reference model: a turn is a budget of TMS*CPM running cycles; ms_left
  // is whatever whole milliseconds of that budget remain.
  int m_st  = 0;
  int m_pl  = 0;
  int m_tu  = 0;
  int m_el  = 0;
  int m_to  = 0;

  function automatic int m_ms();
    if (m_st == 1 || m_st == 2) return TMS - (m_el / CPM);
    return 0;
  endfunction

  task automatic m_end_turn(input int to);
    m_to = to;
    m_tu = m_tu + 1;
    m_el = 0;
    if (m_tu == MAXT) m_st = 3;
    else              m_pl = (m_pl + 1) % 4;
  endtask

  task automatic model_step();
    if (rst) begin
      m_st = 0; m_pl = 0; m_tu = 0; m_el = 0; m_to = 0;
    end else begin
      m_to = 0;
      case (m_st)
        0, 3: if (start) begin
          m_st = 1; m_pl = 0; m_tu = 0; m_el = 0;
        end
        1: begin
          if (pause)                      m_st = 2;
          else if (done[m_pl])            m_end_turn(0);
          else if (m_el + 1 == TMS * CPM) m_end_turn(1);
          else                            m_el = m_el + 1;
        end
        default: if (!pause) m_st = 1;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive inputs, let one rising edge pass (model advances with it), sample 1 unit later.
  task automatic apply(input logic r, input logic s, input logic p, input logic [3:0] d);
    rst = r; start = s; pause = p; done = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int pl, input int ms,
                         input int tu, input int to);
    chk({tag, ".state"},         int'(state),         st);
    chk({tag, ".active_player"}, int'(active_player), pl);
    chk({tag, ".ms_left"},       int'(ms_left),       ms);
    chk({tag, ".turn_count"},    int'(turn_count),    tu);
    chk({tag, ".timeout"},       int'(timeout),       to);
  endtask

  typedef struct {
    logic       r, s, p;
    logic [3:0] d;
    int         st, pl, ms, tu, to;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic s, input logic p, input logic [3:0] d,
                               input int st, input int pl, input int ms, input int tu, input int to);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.d = d;
    v.st = st; v.pl = pl; v.ms = ms; v.tu = tu; v.to = to;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    int        early_to;
    logic      r, s;
    logic [3:0] d;
    logic [3:0] one;
    logic       p;

    // Reset, start, first decrement, foreign/own done, pause hold and resume.
    vecs[0]  = mkv(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 1, 0, 4'b0000, 1, 0, 5, 0, 0);
    vecs[3]  = mkv(0, 0, 0, 4'b0000, 1, 0, 5, 0, 0);
    vecs[4]  = mkv(0, 0, 0, 4'b0000, 1, 0, 5, 0, 0);
    vecs[5]  = mkv(0, 0, 0, 4'b0000, 1, 0, 5, 0, 0);
    vecs[6]  = mkv(0, 0, 0, 4'b0000, 1, 0, 4, 0, 0);
    vecs[7]  = mkv(0, 0, 0, 4'b0010, 1, 0, 4, 0, 0);
    vecs[8]  = mkv(0, 0, 0, 4'b0001, 1, 1, 5, 1, 0);
    vecs[9]  = mkv(0, 1, 0, 4'b0000, 1, 1, 5, 1, 0);
    vecs[10] = mkv(0, 0, 0, 4'b0001, 1, 1, 5, 1, 0);
    vecs[11] = mkv(0, 0, 1, 4'b0000, 2, 1, 5, 1, 0);
    vecs[12] = mkv(0, 0, 1, 4'b0000, 2, 1, 5, 1, 0);
    vecs[13] = mkv(0, 1, 1, 4'b0010, 2, 1, 5, 1, 0);
    vecs[14] = mkv(0, 0, 0, 4'b0000, 1, 1, 5, 1, 0);
    vecs[15] = mkv(0, 0, 0, 4'b0000, 1, 1, 5, 1, 0);
    vecs[16] = mkv(0, 0, 0, 4'b0000, 1, 1, 4, 1, 0);
    vecs[17] = mkv(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pl, vecs[i].ms, vecs[i].tu, vecs[i].to);
    end

    // Turn expiry with no done: pulse exactly at 20 cycles, exactly one cycle wide.
    apply(1, 0, 0, 4'b0000);
    apply(0, 1, 0, 4'b0000);
    early_to = 0;
    for (int i = 0; i < 19; i++) begin
      apply(0, 0, 0, 4'b0000);
      if (timeout) early_to++;
    end
    chk("no_early_timeout", early_to, 0);
    apply(0, 0, 0, 4'b0000);
    chk_all("expire", 1, 1, 5, 1, 1);
    apply(0, 0, 0, 4'b0000);
    chk("timeout_one_cycle", int'(timeout), 0);

    // Done on the expiring tick wins, then the final turn ends the game.
    for (int i = 0; i < 18; i++) apply(0, 0, 0, 4'b0000);
    chk("ms_before_expiry", int'(ms_left), 1);
    apply(0, 0, 0, 4'b0010);
    chk_all("done_vs_expire", 1, 2, 5, 2, 0);
    apply(0, 0, 0, 4'b0100);
    chk_all("game_over", 3, 2, 0, 3, 0);
    apply(0, 0, 0, 4'b1111);
    chk_all("over_hold", 3, 2, 0, 3, 0);
    apply(0, 1, 0, 4'b0000);
    chk_all("restart", 1, 0, 5, 0, 0);

    // Reset mid-turn and while paused.
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 4'b0000);
    apply(1, 0, 0, 4'b0001);
    chk_all("rst_run", 0, 0, 0, 0, 0);
    apply(0, 1, 0, 4'b0000);
    apply(0, 0, 1, 4'b0000);
    apply(0, 0, 1, 4'b0000);
    chk("paused", int'(state), 2);
    apply(1, 1, 1, 4'b0000);
    chk_all("rst_pause", 0, 0, 0, 0, 0);

    // Randomized run against the reference model.
    one = 4'b0001;
    p = 1'b0;
    apply(1, 0, 0, 4'b0000);
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) p = ~p;
      if ($urandom_range(0, 24) == 0)      d = one << $urandom_range(0, 3);
      else if ($urandom_range(0, 39) == 0) d = 4'($urandom_range(0, 15));
      else                                 d = 4'b0000;
      apply(r, s, p, d);
      chk_all($sformatf("rnd%0d", i), m_st, m_pl, m_ms(), m_tu, m_to);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/round_scheduler.md
ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, clock cycles per millisecond tick.
REQ-002 Parameter TURN_MS, default 5000, turn time limit in ms; legal range 1..65535.
REQ-003 Parameter MAX_TURNS, default 40, turns per game; legal range 1..255.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  single-cycle pulse; begins a game from IDLE or OVER.
REQ-007 pause  input  1  level; high freezes the running turn.
REQ-008 done  input  4  per-player end-of-turn pulse; bit i = player i.
REQ-009 active_player  output  2  player owning the current turn.
REQ-010 ms_left  output  16  milliseconds remaining in the current turn.
REQ-011 turn_count  output  8  turns completed in the current game.
REQ-012 timeout  output  1  one-cycle pulse when a turn expires.
REQ-013 state  output  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.

Function
REQ-014 Block SHALL share one internal ms tick source among 4 players, round-robin, one turn at a time.
REQ-015 IDLE: start -> RUN next cycle with active_player=0, ms_left=TURN_MS, turn_count=0, tick counter cleared.
REQ-016 RUN: each ms tick SHALL decrement ms_left by 1, registered, visible the cycle after the tick.
REQ-017 RUN: done[active_player]=1 SHALL end the turn: active_player+1 mod 4, ms_left=TURN_MS, turn_count+1, tick counter cleared, all in the same next-cycle update.
REQ-018 done bits of non-active players SHALL be ignored in every state.
REQ-019 RUN: tick while ms_left==1 SHALL expire the turn: timeout=1 for exactly one cycle, then same advance as REQ-017.
REQ-020 Same cycle done[active_player] and expiring tick: done wins, no timeout pulse.
REQ-021 A turn end making turn_count==MAX_TURNS SHALL enter OVER; ms_left=0, active_player held, tick counter disabled.
REQ-022 RUN with pause=1 -> PAUSE; tick counter SHALL hold its count (partial ms preserved), ms_left frozen.
REQ-023 PAUSE with pause=0 -> RUN; counting resumes from held value.
REQ-024 PAUSE: done and start ignored.
REQ-025 start in RUN or PAUSE ignored; start in OVER behaves as in IDLE (REQ-015).
REQ-026 Tick counter SHALL count 0..CLK_PER_MS-1 and emit tick on the wrap cycle; enabled only in RUN.
REQ-027 turn_count SHALL never wrap; ms_left SHALL never underflow below 0.

Reset
REQ-028 rst=1 SHALL force state=IDLE, active_player=0, ms_left=0, turn_count=0, timeout=0, tick counter=0 at the next rising edge.
REQ-029 rst SHALL take priority over every other input, including mid-turn and in PAUSE.

Structure
REQ-030 State encodings and NUM_PLAYERS=4 SHALL live in shared package game_pkg.
REQ-031 Tick counter SHALL be one sub-module ms_tick_gen (ports clk, rst, enable, clear, tick; clear priority over enable; enable low holds count).
REQ-032 Controller FSM and registers in round_scheduler; all outputs registered.

Verification (CLK_PER_MS=4, TURN_MS=5, MAX_TURNS=3)
REQ-033 rst 2 cycles, start -> state=1, active_player=0, ms_left=5; ms_left=4 after 4 cycles.
REQ-034 No done for 20 cycles after start -> timeout pulse once, active_player=1, ms_left=5, turn_count=1.
REQ-035 done=4'b0010 while player 0 active -> no effect; done=4'b0001 -> active_player=1, turn_count=1.
REQ-036 pause high for 10 cycles 2 cycles into an ms -> ms_left unchanged; after release next decrement after exactly 2 cycles.
REQ-037 done[active] same cycle as expiring tick -> no timeout; three turn ends -> state=3, ms_left=0; start -> state=1, turn_count=0.
REQ-038 rst asserted mid-RUN and in PAUSE -> all outputs to REQ-028 values next cycle.
